// File: rtl/uart_rx_buffer_if.sv
// Byte-buffer host/receiver signal bundle for uart_rx_buffer.
// slave = buffer side, master = receiver/host side.
interface uart_rx_buffer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;

  modport slave (
    input  rx_data, rx_done, rd_en, clr_err,
    output rd_data, rd_valid, empty, full, count, overrun
  );

  modport master (
    output rx_data, rx_done, rd_en, clr_err,
    input  rd_data, rd_valid, empty, full, count, overrun
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// Circular receive FIFO between the UART receiver and a host reader, with sticky overrun.
// Define UART_RX_BUFFER_OVERWRITE_EN to overwrite the oldest byte on overrun instead of dropping.
module uart_rx_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic             p_clk,
  input logic             reset,
  uart_rx_buffer_if.slave bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overrun_q, overrun_d;
  logic              rx_done_q;

  logic empty, full;
  logic wr_stb, rd_accept, wr_accept, ovr_evt, mem_we;

  assign empty = (count_q == '0);
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));

  always_comb begin
    wr_stb    = bus.rx_done & ~rx_done_q;
    rd_accept = bus.rd_en & ~empty;
    // A read in the same cycle frees a slot, so only an unpaired write to a full FIFO overruns.
    ovr_evt   = wr_stb & full & ~rd_accept;
    wr_accept = wr_stb & ~ovr_evt;
`ifdef UART_RX_BUFFER_OVERWRITE_EN
    mem_we    = wr_stb;
`else
    mem_we    = wr_accept;
`endif
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_accept;
    overrun_d  = overrun_q;

    if (mem_we) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
`ifdef UART_RX_BUFFER_OVERWRITE_EN
    // Overwriting the oldest slot drops it, so the read side skips past it.
    if (ovr_evt) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
`endif

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (ovr_evt)          overrun_d = 1'b1;
    else if (bus.clr_err) overrun_d = 1'b0;
  end

  always_ff @(posedge p_clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      rx_done_q  <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
      rx_done_q  <= bus.rx_done;
    end
  end

  always_ff @(posedge p_clk) begin
    if (!reset && mem_we) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus random traffic vs a queue model.
module tb_uart_rx_buffer;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_buffer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_rx_buffer #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(4)) dut (
    .p_clk (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO is a plain queue of bytes.
  logic [7:0] mq[$];
  logic [7:0] m_rd_data  = '0;
  logic       m_rd_valid = 1'b0;
  logic       m_ovr      = 1'b0;
  logic       m_prev     = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic done, input logic [7:0] d,
                       input logic rd, input logic clr);
    logic stb, racc, was_full;
    if (r) begin
      mq.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovr      = 1'b0;
      m_prev     = 1'b1;
      return;
    end
    stb      = done && !m_prev;
    m_prev   = done;
    racc     = rd && (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    m_rd_valid = racc;
    if (racc) m_rd_data = mq.pop_front();
    if (clr) m_ovr = 1'b0;
    if (stb) begin
      if (!was_full || racc) mq.push_back(d);
      else begin
        m_ovr = 1'b1;
`ifdef UART_RX_BUFFER_OVERWRITE_EN
        void'(mq.pop_front());
        mq.push_back(d);
`endif
      end
    end
  endtask

  task automatic step(input logic r, input logic done, input logic [7:0] d,
                      input logic rd, input logic clr);
    @(negedge clk);
    rst         = r;
    bus.rx_done = done;
    bus.rx_data = d;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    @(posedge clk);
    model(r, done, d, rd, clr);
    #1;
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
    chk("rd_data",  32'(bus.rd_data),  32'(m_rd_data));
    chk("count",    32'(bus.count),    32'(mq.size()));
    chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
    chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
    chk("overrun",  32'(bus.overrun),  32'(m_ovr));
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
    step(1'b0, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic read1();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_b;
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h77;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;

    // Reset with rx_done held high across release: no write.
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("hold_no_write", 32'(bus.count), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Level-held rx_done writes once.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send(8'hA5);
    chk("two_count", 32'(bus.count), 2);
    read1();
    chk("rd0_data", 32'(bus.rd_data), 32'h77);
    chk("rd0_valid", 32'(bus.rd_valid), 1);
    chk("rd0_count", 32'(bus.count), 1);
    read1();
    chk("rd1_data", 32'(bus.rd_data), 32'hA5);
    chk("rd1_empty", 32'(bus.empty), 1);
    read1();
    chk("rd_empty_valid", 32'(bus.rd_valid), 0);
    chk("rd_empty_hold", 32'(bus.rd_data), 32'hA5);

    // Fill, overrun, drain, clear.
    for (int i = 0; i < 16; i++) send(8'(i));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 16);
    send(8'hFF);
    chk("ovr_set", 32'(bus.overrun), 1);
    chk("ovr_count", 32'(bus.count), 16);
    for (int i = 0; i < 16; i++) begin
      read1();
`ifdef UART_RX_BUFFER_OVERWRITE_EN
      exp_b = (i == 15) ? 8'hFF : 8'(i + 1);
`else
      exp_b = 8'(i);
`endif
      chk("drain_data", 32'(bus.rd_data), 32'(exp_b));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("ovr_sticky", 32'(bus.overrun), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clr", 32'(bus.overrun), 0);

    // Full FIFO with simultaneous read and write.
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    chk("fullrw_ovr", 32'(bus.overrun), 0);
    chk("fullrw_count", 32'(bus.count), 16);
    chk("fullrw_data", 32'(bus.rd_data), 32'h20);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) read1();
    chk("fullrw_last", 32'(bus.rd_data), 32'h5A);
    chk("fullrw_empty", 32'(bus.empty), 1);

    // Empty FIFO with simultaneous read and write: no bypass.
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    chk("emptyrw_valid", 32'(bus.rd_valid), 0);
    chk("emptyrw_count", 32'(bus.count), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    read1();
    chk("emptyrw_data", 32'(bus.rd_data), 32'h3C);

    // Pointer wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) send(8'(8'h40 + r * 16 + i));
      for (int i = 0; i < 10; i++) begin
        read1();
        chk("wrap_data", 32'(bus.rd_data), 32'(8'h40 + r * 16 + i));
      end
    end
    chk("wrap_count", 32'(bus.count), 0);

    // Reset mid-stream.
    for (int i = 0; i < 5; i++) send(8'(8'h90 + i));
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_empty", 32'(bus.empty), 1);
    chk("midrst_valid", 32'(bus.rd_valid), 0);

    // Random traffic: fill-biased phase, then drain-biased phase.
    for (int i = 0; i < 3000; i++) begin
      logic r, dn, rd, cl;
      r  = ($urandom_range(0, 399) == 0);
      dn = ($urandom_range(0, 2) == 0);
      rd = (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 15) == 0);
      step(r, dn, 8'($urandom), rd, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side byte buffer sitting between the UART `receiver` and the consuming logic.
- Captures each completed byte from the receiver (rx_data/rx_done) into a circular FIFO.
- Presents a registered read interface with occupancy and error status.
- Decouples the baud-rate-paced serial link from a bursty host reader.
- Flags overrun when the host falls behind.

Parameters:
- DATA_W, 8, byte width; matches receiver rx_data.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- p_clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  DATA_W  byte from receiver; valid while rx_done high.
- rx_done  input  1  receiver byte-complete flag; may be held high for more than one p_clk.
- rd_en  input  1  host read request.
- clr_err  input  1  clears sticky overrun flag.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse; rd_data valid.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overrun  output  1  sticky; a byte arrived while full.

Behaviour:
- Reset (synchronous, p_clk edge with reset=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_data=0, rd_valid=0, overrun=0.
  - empty=1, full=0.
  - rx_done_q=1, so a rx_done already high at reset release does not write.
- Reset mid-operation discards all stored bytes; memory contents are don't-care.
- Write strobe:
  - wr_stb = rx_done & ~rx_done_q (rising-edge detect); rx_done_q registers rx_done every cycle.
  - A level-held rx_done therefore writes exactly once per byte.
  - rx_data is sampled in the same cycle as wr_stb.
- Write accepted when wr_stb & ~full:
  - mem[wr_ptr] <= rx_data.
  - wr_ptr increments modulo DEPTH (natural wrap of ADDR_W bits).
- Read accepted when rd_en & ~empty:
  - rd_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - rd_valid=1 in the following cycle (latency 1).
- rd_en while empty: ignored; rd_valid=0, rd_data holds its last value, no error flag.
- rd_valid is deasserted in every cycle without an accepted read.
- count update per cycle:
  - +1 on write only; −1 on read only.
  - Unchanged on both or neither.
  - empty = (count==0); full = (count==DEPTH); both derived from the registered count.
- Simultaneous write and read:
  - When not empty: both occur; count unchanged.
  - When full: the read frees a slot, so the write is accepted and overrun is not set.
  - When empty: the write occurs, the read is ignored (no bypass), count becomes 1.
- Overrun:
  - wr_stb & full & ~rd_accept sets overrun=1; the byte is dropped (default build).
  - clr_err clears overrun.
  - If clr_err and a new overrun event occur in the same cycle, set wins.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: UART_RX_BUFFER_OVERWRITE_EN.
- Defined:
  - An overrun write (wr_stb & full & ~rd_accept) stores rx_data at wr_ptr, overwriting the oldest entry.
  - Both wr_ptr and rd_ptr advance; count stays DEPTH.
  - overrun is still set.
  - The FIFO always holds the most recent DEPTH bytes.
- Not defined: the newest byte is dropped and pointers are unchanged, as in Behaviour.

Test Plan:
- Reset, hold rx_done=1 across reset release with rx_data=0x77 -> no write; count=0, empty=1.
- Pulse rx_done with 0x77 (held 5 cycles), then 0xA5 -> count=2; rd_en one cycle -> next cycle rd_data=0x77, rd_valid=1, count=1; second read -> 0xA5, empty=1.
- Write 16 bytes 0x00..0x0F -> full=1, count=16; 17th byte 0xFF -> overrun=1, count=16; drain yields 0x00..0x0F; clr_err -> overrun=0.
  - With UART_RX_BUFFER_OVERWRITE_EN: drain yields 0x01..0x0F then 0xFF.
- Full FIFO, rd_en and a write edge (0x5A) in the same cycle -> overrun=0, count=16; 0x5A is read out last.
- Empty FIFO, rd_en and a write edge (0x3C) in the same cycle -> rd_valid=0, count=1; next read returns 0x3C.
- Write 10 bytes, read 10, write 10 more (pointer wrap past 15) -> data returned in order, count returns to 0; assert reset mid-stream -> count=0, empty=1, rd_valid=0 the next cycle.
